apb_rambus_bridge: RTL and testbench

//  Converts MSS FIC APB3 slave-port transfers into RamBus cycles for DMMainPorts.

---
 rtl/apb_rambus_bridge_if.sv | 35 +++
 rtl/apb_rambus_bridge.sv | 163 ++++++++++++++++
 tb/tb_apb_rambus_bridge.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/apb_rambus_bridge_if.sv
// APB3 slave-port and RamBus signal bundle for apb_rambus_bridge.
// slave  : the bridge's view (APB in, RamBus out).
// master : the surrounding fabric's view (APB master plus DMMainPorts).
interface apb_rambus_bridge_if #(
    parameter int ADDR_W = 14,
    parameter int DATA_W = 32
);
    logic              PSEL;
    logic              PENABLE;
    logic              PWRITE;
    logic [ADDR_W-1:0] PADDR;
    logic [DATA_W-1:0] PWDATA;
    logic [DATA_W-1:0] PRDATA;
    logic              PREADY;
    logic              PSLVERR;
    logic [ADDR_W-1:0] RamBusAddress;
    logic [DATA_W-1:0] RamBusDataIn;
    logic              RamBusnCs;
    logic              RamBusWrnRd;
    logic              RamBusLatch;
    logic [DATA_W-1:0] RamBusDataOut;
    logic              RamBusAck;

    modport slave (
        input  PSEL, PENABLE, PWRITE, PADDR, PWDATA, RamBusDataOut, RamBusAck,
        output PRDATA, PREADY, PSLVERR,
        output RamBusAddress, RamBusDataIn, RamBusnCs, RamBusWrnRd, RamBusLatch
    );

    modport master (
        output PSEL, PENABLE, PWRITE, PADDR, PWDATA, RamBusDataOut, RamBusAck,
        input  PRDATA, PREADY, PSLVERR,
        input  RamBusAddress, RamBusDataIn, RamBusnCs, RamBusWrnRd, RamBusLatch
    );
endinterface

// File: rtl/apb_rambus_bridge.sv
// APB3 slave to RamBus bridge for DMMainPorts.
// Each APB transfer becomes one RamBus cycle (Latch strobe, nCs low until Ack).
// Out-of-range addresses and missing Acks complete the APB transfer with
// PSLVERR so the CPU never stalls; errored transfers are counted in ErrCount.
module apb_rambus_bridge #(
    parameter int                ADDR_W         = 14,
    parameter int                DATA_W         = 32,
    parameter logic [ADDR_W-1:0] ADDR_LIMIT     = 14'h3000,
    parameter int                TIMEOUT_CYCLES = 256,
    parameter logic [DATA_W-1:0] ERR_DATA       = 32'hDEADBEEF
) (
    input  logic                 clk,
    input  logic                 rst,
    apb_rambus_bridge_if.slave   bus,
    output logic [15:0]          ErrCount
);

    localparam int                 TIMER_W   = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TIMER_W-1:0] TIMER_MAX = TIMER_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STROBE = 2'd1,
        WAIT   = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t              r_state;
    logic [TIMER_W-1:0]  r_timer;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic                r_write;
    logic [DATA_W-1:0]   r_prdata;
    logic                r_pready;
    logic                r_pslverr;
    logic                r_ncs;
    logic                r_latch;
    logic [15:0]         r_errcnt;

    logic                w_in_range;
    logic                w_finish;
    logic                w_fin_err;
    logic                w_fin_write;
    logic [DATA_W-1:0]   w_fin_rdata;

    // Error counter holds at all-ones instead of wrapping.
    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // Decide whether the current cycle ends the transfer, and with what status.
    // PENABLE is deliberately not looked at: a transfer starts on PSEL alone.
    always_comb begin
        w_in_range  = (bus.PADDR < ADDR_LIMIT);
        w_finish    = 1'b0;
        w_fin_err   = 1'b0;
        w_fin_write = r_write;
        case (r_state)
            IDLE: begin
                if (bus.PSEL && !w_in_range) begin
                    w_finish    = 1'b1;
                    w_fin_err   = 1'b1;
                    w_fin_write = bus.PWRITE;
                end
            end
            STROBE: begin
                if (bus.RamBusAck) begin
                    w_finish = 1'b1;
                end
            end
            WAIT: begin
                if (bus.RamBusAck) begin
                    w_finish = 1'b1;
                end else if (r_timer == TIMER_MAX) begin
                    w_finish  = 1'b1;
                    w_fin_err = 1'b1;
                end
            end
            default: begin
                w_finish = 1'b0;
            end
        endcase
        w_fin_rdata = w_fin_err ? ERR_DATA : bus.RamBusDataOut;
    end

    // Transfer FSM with registered APB and RamBus outputs.
    // Entering DONE raises PREADY, so DONE is the APB completion cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_timer   <= '0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_write   <= 1'b0;
            r_prdata  <= '0;
            r_pready  <= 1'b0;
            r_pslverr <= 1'b0;
            r_ncs     <= 1'b1;
            r_latch   <= 1'b0;
            r_errcnt  <= '0;
        end else begin
            r_latch   <= 1'b0;
            r_pready  <= 1'b0;
            r_pslverr <= 1'b0;

            if (w_finish) begin
                r_state   <= DONE;
                r_ncs     <= 1'b1;
                r_pready  <= 1'b1;
                r_pslverr <= w_fin_err;
                if (!w_fin_write) begin
                    r_prdata <= w_fin_rdata;
                end
                if (w_fin_err) begin
                    r_errcnt <= sat_inc(r_errcnt);
                end
            end

            case (r_state)
                IDLE: begin
                    if (bus.PSEL) begin
                        r_addr  <= bus.PADDR;
                        r_wdata <= bus.PWDATA;
                        r_write <= bus.PWRITE;
                        r_timer <= '0;
                        if (w_in_range) begin
                            r_ncs   <= 1'b0;
                            r_latch <= 1'b1;
                            r_state <= STROBE;
                        end
                    end
                end
                STROBE: begin
                    if (!bus.RamBusAck) begin
                        r_state <= WAIT;
                    end
                end
                WAIT: begin
                    if (!w_finish) begin
                        r_timer <= r_timer + 1'b1;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bus.PRDATA        = r_prdata;
    assign bus.PREADY        = r_pready;
    assign bus.PSLVERR       = r_pslverr;
    assign bus.RamBusAddress = r_addr;
    assign bus.RamBusDataIn  = r_wdata;
    assign bus.RamBusnCs     = r_ncs;
    assign bus.RamBusWrnRd   = r_write;
    assign bus.RamBusLatch   = r_latch;
    assign ErrCount          = r_errcnt;

endmodule

// File: tb/tb_apb_rambus_bridge.sv
// Testbench for apb_rambus_bridge: directed APB transfers against a RamBus
// responder, with a scoreboard queue checked by an independent PREADY monitor.
module tb_apb_rambus_bridge;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] err_count;

    apb_rambus_bridge_if #(.ADDR_W(14), .DATA_W(32)) bus ();

    apb_rambus_bridge #(
        .ADDR_W(14), .DATA_W(32), .ADDR_LIMIT(14'h3000),
        .TIMEOUT_CYCLES(256), .ERR_DATA(32'hDEADBEEF)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .ErrCount (err_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        logic [15:0] cnt;
        logic [13:0] addr;
    } exp_t;

    exp_t        sbq[$];
    int          n_checks = 0;
    int          n_pass   = 0;
    int          cyc      = 0;

    // Reference model state
    logic [31:0] m_prdata = 32'h0;
    logic [15:0] m_errcnt = 16'h0;

    // Responder control
    int          ack_at     = -1;
    logic [31:0] ack_data   = 32'h0;
    int          pulse_req  = 0;
    int          pulse_done = 0;
    logic [31:0] pulse_data = 32'h0;

    // RamBus observation
    int          latch_cnt = 0;
    int          ncs_low   = 0;
    logic [13:0] lat_addr  = '0;
    logic [31:0] lat_data  = '0;
    logic        lat_wr    = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    always @(posedge clk) cyc++;

    initial begin
        bus.RamBusAck     = 1'b0;
        bus.RamBusDataOut = 32'h0;
        forever begin
            @(negedge clk);
            if (pulse_req != pulse_done) begin
                pulse_done++;
                bus.RamBusAck     = 1'b1;
                bus.RamBusDataOut = pulse_data;
                @(negedge clk);
                bus.RamBusAck     = 1'b0;
            end else if (bus.RamBusLatch === 1'b1 && ack_at >= 0) begin
                for (int k = 0; k < ack_at; k++) @(negedge clk);
                bus.RamBusAck     = 1'b1;
                bus.RamBusDataOut = ack_data;
                @(negedge clk);
                bus.RamBusAck     = 1'b0;
                bus.RamBusDataOut = 32'h0;
            end
        end
    end

    always @(negedge clk) begin
        if (bus.RamBusLatch === 1'b1) begin
            latch_cnt++;
            lat_addr = bus.RamBusAddress;
            lat_data = bus.RamBusDataIn;
            lat_wr   = bus.RamBusWrnRd;
        end
        if (bus.RamBusnCs === 1'b0) ncs_low++;
    end

    always @(negedge clk) begin
        if (bus.PREADY === 1'b1) begin
            if (sbq.size() == 0) begin
                chk("spurious_pready", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sbq.pop_front();
                chk("prdata",  bus.PRDATA, e.rdata);
                chk("pslverr", {31'd0, bus.PSLVERR}, {31'd0, e.err});
                chk("errcount", {16'd0, err_count}, {16'd0, e.cnt});
                chk("ncs_in_done", {31'd0, bus.RamBusnCs}, 32'd1);
                chk("addr_held", {18'd0, bus.RamBusAddress}, {18'd0, e.addr});
            end
        end
    end

    task automatic apb_xfer(input string name, input logic wr, input logic [13:0] addr,
                            input logic [31:0] wdata, input int ack_cyc,
                            input logic [31:0] rdata, input logic exp_err,
                            input int exp_lat, input int exp_latch, input int exp_ncs);
        exp_t e;
        int   c0;
        int   n;
        if (exp_err) m_errcnt = m_errcnt + 16'd1;
        if (!wr) m_prdata = exp_err ? 32'hDEADBEEF : rdata;
        e.rdata = m_prdata;
        e.err   = exp_err;
        e.cnt   = m_errcnt;
        e.addr  = addr;
        sbq.push_back(e);
        ack_at   = ack_cyc;
        ack_data = rdata;
        @(posedge clk);
        #1;
        latch_cnt   = 0;
        ncs_low     = 0;
        bus.PSEL    = 1'b1;
        bus.PENABLE = 1'b0;
        bus.PWRITE  = wr;
        bus.PADDR   = addr;
        bus.PWDATA  = wdata;
        @(posedge clk);
        #1;
        c0 = cyc;
        bus.PENABLE = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (bus.PREADY !== 1'b1 && n < 400);
        if (n >= 400) chk({name, "_timeout"}, 32'd0, 32'd1);
        else chk({name, "_latency"}, cyc - c0 + 1, exp_lat);
        chk({name, "_latch_cnt"}, latch_cnt, exp_latch);
        chk({name, "_ncs_low"}, ncs_low, exp_ncs);
        if (exp_latch > 0) begin
            chk({name, "_lat_addr"}, {18'd0, lat_addr}, {18'd0, addr});
            chk({name, "_lat_wrnrd"}, {31'd0, lat_wr}, {31'd0, wr});
            if (wr) chk({name, "_datain"}, lat_data, wdata);
        end
        @(posedge clk);
        #1;
        bus.PSEL    = 1'b0;
        bus.PENABLE = 1'b0;
        ack_at      = -1;
    endtask

    initial begin
        bus.PSEL    = 1'b0;
        bus.PENABLE = 1'b0;
        bus.PWRITE  = 1'b0;
        bus.PADDR   = '0;
        bus.PWDATA  = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_prdata",  bus.PRDATA, 32'h0);
        chk("rst_pready",  {31'd0, bus.PREADY}, 32'd0);
        chk("rst_pslverr", {31'd0, bus.PSLVERR}, 32'd0);
        chk("rst_ncs",     {31'd0, bus.RamBusnCs}, 32'd1);
        chk("rst_latch",   {31'd0, bus.RamBusLatch}, 32'd0);
        chk("rst_wrnrd",   {31'd0, bus.RamBusWrnRd}, 32'd0);
        chk("rst_addr",    {18'd0, bus.RamBusAddress}, 32'd0);
        chk("rst_datain",  bus.RamBusDataIn, 32'h0);
        chk("rst_errcnt",  {16'd0, err_count}, 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;

        // name, wr, addr, wdata, ack_at, rdata, err, latency, latches, nCs-low cycles
        apb_xfer("t1_write", 1'b1, 14'h0040, 32'h12345678, 1, 32'h0,        1'b0, 3,   1, 2);
        apb_xfer("t2_read",  1'b0, 14'h0100, 32'h0,        6, 32'hCAFEF00D, 1'b0, 8,   1, 7);
        apb_xfer("t3_tmo",   1'b0, 14'h0200, 32'h0,       -1, 32'h0,        1'b1, 258, 1, 257);
        apb_xfer("t4_oor",   1'b1, 14'h3000, 32'h55AA55AA,-1, 32'h0,        1'b1, 1,   0, 0);

        // Reset while the bridge waits for an Ack
        @(posedge clk);
        #1;
        bus.PSEL   = 1'b1;
        bus.PWRITE = 1'b0;
        bus.PADDR  = 14'h0300;
        @(posedge clk);
        #1 bus.PENABLE = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        rst         = 1'b1;
        bus.PSEL    = 1'b0;
        bus.PENABLE = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("t5_ncs",    {31'd0, bus.RamBusnCs}, 32'd1);
        chk("t5_pready", {31'd0, bus.PREADY}, 32'd0);
        chk("t5_errcnt", {16'd0, err_count}, 32'd0);
        chk("t5_prdata", bus.PRDATA, 32'h0);
        m_prdata = 32'h0;
        m_errcnt = 16'h0;
        pulse_data = 32'h77777777;
        pulse_req++;
        repeat (4) @(negedge clk);
        apb_xfer("t5_read",  1'b0, 14'h0104, 32'h0,        1, 32'h0BADF00D, 1'b0, 3,   1, 2);

        // Stale Ack in IDLE, then Ack during STROBE
        pulse_data = 32'h11111111;
        pulse_req++;
        repeat (4) @(negedge clk);
        apb_xfer("t6_read",  1'b0, 14'h0208, 32'h0,        0, 32'h5A5AA5A5, 1'b0, 2,   1, 1);

        repeat (4) @(negedge clk);
        chk("sb_empty", sbq.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
